pipelined_add_sub_core: RTL and testbench
=========================================

PIPELINED_ADD_SUB_CORE -- requirements
Module: pipelined_add_sub_core

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits (legal: 3..64).
REQ-002 SHALL have parameter CHUNK, default 4, bits added per pipeline stage; WIDTH SHALL be a multiple of CHUNK; STAGES = WIDTH/CHUNK.
REQ-003 SHALL have port in_clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port in_rst_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port in_valid  input  1  operand pair presented this cycle.
REQ-006 SHALL have port in_ready  output  1  block accepts operands this cycle.
REQ-007 SHALL have port in_a  input  WIDTH  augend/minuend.
REQ-008 SHALL have port in_b  input  WIDTH  addend/subtrahend.
REQ-009 SHALL have port in_sub  input  1  0 = a+b, 1 = a-b.
REQ-010 SHALL have port out_ready  input  1  downstream accepts result this cycle.
REQ-011 SHALL have port out_valid  output  1  s_out/flags hold a valid result.
REQ-012 SHALL have port s_out  output  WIDTH  sum/difference, modulo 2^WIDTH.
REQ-013 SHALL have port c_out  output  1  carry out of MSB (subtract: 1 = no borrow).
REQ-014 SHALL have port v_out  output  1  two's-complement signed overflow.
REQ-015 SHALL have port z_out  output  1  s_out equals zero.

Function
REQ-016 SHALL accept an operation when in_valid && in_ready are both high at a rising edge ("transfer").
REQ-017 SHALL form the effective addend as in_b when in_sub=0 and ~in_b with carry-in 1 when in_sub=1; carry-in otherwise 0.
REQ-018 SHALL add chunk k (bits [k*CHUNK +: CHUNK]) in pipeline stage k, using the registered carry from stage k-1; higher chunks and completed low chunks SHALL be carried forward in stage registers.
REQ-019 SHALL present the result on s_out/c_out/v_out/z_out with out_valid=1 exactly STAGES cycles after the accepting edge when no stall occurs.
REQ-020 SHALL compute v_out = carry into MSB XOR carry out of MSB; z_out = (s_out == 0).
REQ-021 SHALL sustain one transfer per cycle: in_ready = !out_valid || out_ready.
REQ-022 SHALL, when out_valid=1 and out_ready=0, freeze every stage register, valid bit and output; s_out/flags SHALL stay stable until out_ready=1.
REQ-023 SHALL propagate a bubble (stage valid=0) when no transfer occurs; bubbles SHALL not produce out_valid.
REQ-024 SHALL hold outputs unchanged when out_valid falls; only out_valid qualifies them.
REQ-025 SHALL ignore in_a/in_b/in_sub when no transfer occurs.
REQ-026 SHALL, on simultaneous result consumption and new transfer, advance the pipeline with no lost or duplicated result.

Reset
REQ-027 SHALL, while in_rst_n=0 at a rising edge, clear all stage valid bits, out_valid, s_out, c_out, v_out to 0 and set z_out to 0.
REQ-028 SHALL discard all in-flight operations on reset, including reset asserted mid-pipeline or during a stall; no result from before reset SHALL appear afterwards.
REQ-029 SHALL drive in_ready=1 during and immediately after reset; the first transfer is accepted on the first edge with in_rst_n=1.

Verification
REQ-030 WIDTH=8, CHUNK=4: add 0xFF + 0x01 -> after 2 cycles s_out=0x00, c_out=1, v_out=0, z_out=1.
REQ-031 WIDTH=8, CHUNK=4: add 0x7F + 0x01 -> s_out=0x80, c_out=0, v_out=1, z_out=0; sub 0x05 - 0x07 -> s_out=0xFE, c_out=0, v_out=0.
REQ-032 WIDTH=8, CHUNK=4: 10 back-to-back transfers, out_ready=1 -> 10 consecutive out_valid cycles, results in order, in_ready constantly 1.
REQ-033 Stall: out_ready=0 for 5 cycles with results pending -> in_ready=0, outputs stable; release -> all results delivered once, in order.
REQ-034 Reset: in_rst_n=0 for one cycle while two operations are in flight -> out_valid=0 and outputs zero next cycle; neither discarded result ever appears.
REQ-035 WIDTH=3, CHUNK=3: exhaustive 64 adds -> latency 1; s_out and c_out equal the 4-bit sum of in_a and in_b.

Source files
------------

// File: rtl/pipelined_add_sub_if.sv
// Operand/result handshake bundle for pipelined_add_sub_core.
// The master drives operands and out_ready; the slave (the core) returns results and flags.
interface pipelined_add_sub_if #(
    parameter int unsigned WIDTH = 8
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_sub;
    logic             out_ready;
    logic             out_valid;
    logic [WIDTH-1:0] s_out;
    logic             c_out;
    logic             v_out;
    logic             z_out;

    modport master (
        output in_valid, in_a, in_b, in_sub, out_ready,
        input  in_ready, out_valid, s_out, c_out, v_out, z_out
    );

    modport slave (
        input  in_valid, in_a, in_b, in_sub, out_ready,
        output in_ready, out_valid, s_out, c_out, v_out, z_out
    );
endinterface

// File: rtl/pipelined_add_sub_core.sv
// Carry-pipelined adder/subtractor: one CHUNK-bit slice per stage, ripple carry held in registers.
// A single stall enable freezes the whole pipe while an unconsumed result sits at the output.
module pipelined_add_sub_core #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CHUNK = 4
) (
    input logic                in_clk,
    input logic                in_rst_n,
    pipelined_add_sub_if.slave bus
);
    localparam int unsigned Stages = WIDTH / CHUNK;

    logic advance;
    logic v_d, z_d;
    logic v_q, z_q;

    for (genvar k = 0; k < Stages; k++) begin : g_stage
        // Rem: operand bits not yet consumed; SumW: result bits produced so far.
        localparam int unsigned Rem  = WIDTH - k * CHUNK;
        localparam int unsigned SumW = (k + 1) * CHUNK;

        logic            vld_src;
        logic            cin;
        logic [Rem-1:0]  a_src;
        logic [Rem-1:0]  b_src;
        logic [CHUNK:0]  sum;
        logic [SumW-1:0] s_d;
        logic [SumW-1:0] s_q;
        logic            vld_q;
        logic            c_q;

        if (k == 0) begin : g_in
            assign vld_src = bus.in_valid && advance;
            assign a_src   = bus.in_a;
            assign b_src   = bus.in_sub ? ~bus.in_b : bus.in_b;
            assign cin     = bus.in_sub;
            assign s_d     = sum[CHUNK-1:0];
        end else begin : g_mid
            assign vld_src = g_stage[k-1].vld_q;
            assign a_src   = g_stage[k-1].g_fwd.a_q;
            assign b_src   = g_stage[k-1].g_fwd.b_q;
            assign cin     = g_stage[k-1].c_q;
            assign s_d     = {sum[CHUNK-1:0], g_stage[k-1].s_q};
        end

        assign sum = {1'b0, a_src[CHUNK-1:0]} + {1'b0, b_src[CHUNK-1:0]}
                   + {{CHUNK{1'b0}}, cin};

        always_ff @(posedge in_clk) begin
            if (!in_rst_n) begin
                vld_q <= 1'b0;
                s_q   <= '0;
                c_q   <= 1'b0;
            end else if (advance) begin
                vld_q <= vld_src;
                // Data only loads with a real operation so bubbles leave outputs untouched.
                if (vld_src) begin
                    s_q <= s_d;
                    c_q <= sum[CHUNK];
                end
            end
        end

        if (k < Stages - 1) begin : g_fwd
            logic [Rem-CHUNK-1:0] a_q;
            logic [Rem-CHUNK-1:0] b_q;

            always_ff @(posedge in_clk) begin
                if (!in_rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (advance && vld_src) begin
                    a_q <= a_src[Rem-1:CHUNK];
                    b_q <= b_src[Rem-1:CHUNK];
                end
            end
        end
    end

    assign advance = !g_stage[Stages-1].vld_q || bus.out_ready;

    // Carry into the MSB is recovered from the MSB sum bit and its two operand bits.
    assign v_d = g_stage[Stages-1].a_src[CHUNK-1] ^ g_stage[Stages-1].b_src[CHUNK-1]
               ^ g_stage[Stages-1].sum[CHUNK-1] ^ g_stage[Stages-1].sum[CHUNK];
    assign z_d = (g_stage[Stages-1].s_d == '0);

    always_ff @(posedge in_clk) begin
        if (!in_rst_n) begin
            v_q <= 1'b0;
            z_q <= 1'b0;
        end else if (advance && g_stage[Stages-1].vld_src) begin
            v_q <= v_d;
            z_q <= z_d;
        end
    end

    assign bus.in_ready  = !in_rst_n || advance;
    assign bus.out_valid = g_stage[Stages-1].vld_q;
    assign bus.s_out     = g_stage[Stages-1].s_q;
    assign bus.c_out     = g_stage[Stages-1].c_q;
    assign bus.v_out     = v_q;
    assign bus.z_out     = z_q;
endmodule

// File: tb/tb_pipelined_add_sub_core.sv
// Randomized and directed bench for pipelined_add_sub_core, checked against an arithmetic model.
module tb_pipelined_add_sub_core;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pipelined_add_sub_if #(.WIDTH(8)) bus8 ();
    pipelined_add_sub_if #(.WIDTH(3)) bus3 ();

    pipelined_add_sub_core #(.WIDTH(8), .CHUNK(4)) dut8 (
        .in_clk   (clk),
        .in_rst_n (rst_n),
        .bus      (bus8)
    );

    pipelined_add_sub_core #(.WIDTH(3), .CHUNK(3)) dut3 (
        .in_clk   (clk),
        .in_rst_n (rst_n),
        .bus      (bus3)
    );

    typedef struct packed {
        logic [7:0] s;
        logic       c;
        logic       v;
        logic       z;
    } res_t;

    res_t q8[$];
    res_t q3[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    // Signed-overflow semantics from operand/result signs, not from carries.
    function automatic res_t model(int unsigned w, int unsigned a, int unsigned b, bit sub);
        int unsigned mask;
        int unsigned full;
        bit          sa, sb, ss;
        res_t        r;
        mask = (1 << w) - 1;
        a    = a & mask;
        b    = b & mask;
        full = sub ? a + ((~b) & mask) + 1 : a + b;
        sa   = ((a >> (w - 1)) & 1) != 0;
        sb   = ((b >> (w - 1)) & 1) != 0;
        ss   = ((full >> (w - 1)) & 1) != 0;
        r.s  = 8'(full & mask);
        r.c  = ((full >> w) & 1) != 0;
        r.v  = sub ? ((sa != sb) && (ss != sa)) : ((sa == sb) && (ss != sa));
        r.z  = (full & mask) == 0;
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus8.in_valid = 1'b0; bus8.in_a = '0; bus8.in_b = '0; bus8.in_sub = 1'b0;
        bus8.out_ready = 1'b1;
        bus3.in_valid = 1'b0; bus3.in_a = '0; bus3.in_b = '0; bus3.in_sub = 1'b0;
        bus3.out_ready = 1'b1;
        step();
        step();
        n_cmp++;
        if (bus8.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_out_valid8: got %b want 0", bus8.out_valid);
        end
        n_cmp++;
        if ({bus8.s_out, bus8.c_out, bus8.v_out, bus8.z_out} !== 11'h0) begin
            n_fail++; $display("FAIL reset_outputs8: got %h want 0",
                               {bus8.s_out, bus8.c_out, bus8.v_out, bus8.z_out});
        end
        n_cmp++;
        if (bus8.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_in_ready8: got %b want 1", bus8.in_ready);
        end
        n_cmp++;
        if ({bus3.out_valid, bus3.s_out, bus3.c_out, bus3.v_out, bus3.z_out} !== 7'h0) begin
            n_fail++; $display("FAIL reset_outputs3: got %h want 0",
                               {bus3.out_valid, bus3.s_out, bus3.c_out, bus3.v_out, bus3.z_out});
        end
        n_cmp++;
        if (bus3.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_in_ready3: got %b want 1", bus3.in_ready);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [7:0] a_t [3] = '{8'hFF, 8'h7F, 8'h05};
        logic [7:0] b_t [3] = '{8'h01, 8'h01, 8'h07};
        logic       s_t [3] = '{1'b0, 1'b0, 1'b1};
        res_t       e_t [3] = '{'{8'h00, 1'b1, 1'b0, 1'b1},
                                '{8'h80, 1'b0, 1'b1, 1'b0},
                                '{8'hFE, 1'b0, 1'b0, 1'b0}};
        res_t got;
        for (int i = 0; i < 3; i++) begin
            bus8.in_valid = 1'b1; bus8.in_a = a_t[i]; bus8.in_b = b_t[i]; bus8.in_sub = s_t[i];
            bus8.out_ready = 1'b1;
            #1;
            n_cmp++;
            if (bus8.in_ready !== 1'b1) begin
                n_fail++; $display("FAIL dir%0d_in_ready: got %b want 1", i, bus8.in_ready);
            end
            step();
            bus8.in_valid = 1'b0; bus8.in_a = 8'($urandom); bus8.in_b = 8'($urandom);
            n_cmp++;
            if (bus8.out_valid !== 1'b0) begin
                n_fail++; $display("FAIL dir%0d_early_valid: got %b want 0", i, bus8.out_valid);
            end
            step();
            got = {bus8.s_out, bus8.c_out, bus8.v_out, bus8.z_out};
            n_cmp++;
            if (bus8.out_valid !== 1'b1 || got !== e_t[i]) begin
                n_fail++; $display("FAIL dir%0d_result: got valid=%b %h want valid=1 %h",
                                   i, bus8.out_valid, got, e_t[i]);
            end
            step();
            got = {bus8.s_out, bus8.c_out, bus8.v_out, bus8.z_out};
            n_cmp++;
            if (bus8.out_valid !== 1'b0 || got !== e_t[i]) begin
                n_fail++; $display("FAIL dir%0d_hold: got valid=%b %h want valid=0 %h",
                                   i, bus8.out_valid, got, e_t[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        res_t got, exp;
        bus8.out_ready = 1'b1;
        for (int cyc = 0; cyc < 14; cyc++) begin
            bus8.in_valid = (cyc < 10);
            bus8.in_a = 8'($urandom); bus8.in_b = 8'($urandom); bus8.in_sub = 1'($urandom);
            #1;
            n_cmp++;
            if (bus8.in_ready !== 1'b1) begin
                n_fail++; $display("FAIL b2b_in_ready cyc%0d: got %b want 1", cyc, bus8.in_ready);
            end
            n_cmp++;
            if (bus8.out_valid !== 1'((cyc >= 2) && (cyc < 12))) begin
                n_fail++; $display("FAIL b2b_out_valid cyc%0d: got %b want %b",
                                   cyc, bus8.out_valid, (cyc >= 2) && (cyc < 12));
            end
            if (bus8.out_valid === 1'b1 && q8.size() > 0) begin
                got = {bus8.s_out, bus8.c_out, bus8.v_out, bus8.z_out};
                exp = q8.pop_front();
                n_cmp++;
                if (got !== exp) begin
                    n_fail++; $display("FAIL b2b_result cyc%0d: got %h want %h", cyc, got, exp);
                end
            end
            if (bus8.in_valid && bus8.in_ready)
                q8.push_back(model(8, bus8.in_a, bus8.in_b, bus8.in_sub));
            step();
        end
        bus8.in_valid = 1'b0;
        n_cmp++;
        if (q8.size() != 0) begin
            n_fail++; $display("FAIL b2b_drain: got %0d pending want 0", q8.size());
        end
        q8.delete();
    endtask

    task automatic test_stall();
        res_t got, exp;
        int   delivered = 0;
        for (int cyc = 0; cyc < 14; cyc++) begin
            bus8.in_valid  = (cyc < 8);
            bus8.out_ready = !((cyc >= 3) && (cyc <= 7));
            bus8.in_a = 8'($urandom); bus8.in_b = 8'($urandom); bus8.in_sub = 1'($urandom);
            #1;
            n_cmp++;
            if (bus8.in_ready !== bus8.out_ready) begin
                n_fail++; $display("FAIL stall_in_ready cyc%0d: got %b want %b",
                                   cyc, bus8.in_ready, bus8.out_ready);
            end
            if (bus8.out_valid === 1'b1) begin
                got = {bus8.s_out, bus8.c_out, bus8.v_out, bus8.z_out};
                n_cmp++;
                if (q8.size() == 0) begin
                    n_fail++; $display("FAIL stall_extra cyc%0d: got %h want none", cyc, got);
                end else begin
                    exp = q8[0];
                    if (got !== exp) begin
                        n_fail++; $display("FAIL stall_result cyc%0d: got %h want %h", cyc, got, exp);
                    end
                    if (bus8.out_ready) begin
                        void'(q8.pop_front());
                        delivered++;
                    end
                end
            end
            if (bus8.in_valid && bus8.in_ready)
                q8.push_back(model(8, bus8.in_a, bus8.in_b, bus8.in_sub));
            step();
        end
        bus8.in_valid = 1'b0;
        bus8.out_ready = 1'b1;
        n_cmp++;
        if (delivered != 3 || q8.size() != 0) begin
            n_fail++; $display("FAIL stall_count: got %0d delivered %0d pending want 3 and 0",
                               delivered, q8.size());
        end
        q8.delete();
    endtask

    task automatic test_random();
        res_t got, exp;
        for (int cyc = 0; cyc < 210; cyc++) begin
            bus8.in_valid  = (cyc < 200) && ($urandom_range(3) != 0);
            bus8.out_ready = (cyc >= 200) || ($urandom_range(2) != 0);
            bus8.in_a = 8'($urandom); bus8.in_b = 8'($urandom); bus8.in_sub = 1'($urandom);
            #1;
            n_cmp++;
            if (bus8.in_ready !== (!bus8.out_valid || bus8.out_ready)) begin
                n_fail++; $display("FAIL rnd_in_ready cyc%0d: got %b want %b", cyc,
                                   bus8.in_ready, !bus8.out_valid || bus8.out_ready);
            end
            if (bus8.out_valid === 1'b1) begin
                got = {bus8.s_out, bus8.c_out, bus8.v_out, bus8.z_out};
                n_cmp++;
                if (q8.size() == 0) begin
                    n_fail++; $display("FAIL rnd_extra cyc%0d: got %h want none", cyc, got);
                end else begin
                    exp = q8[0];
                    if (got !== exp) begin
                        n_fail++; $display("FAIL rnd_result cyc%0d: got %h want %h", cyc, got, exp);
                    end
                    if (bus8.out_ready) void'(q8.pop_front());
                end
            end
            if (bus8.in_valid && bus8.in_ready)
                q8.push_back(model(8, bus8.in_a, bus8.in_b, bus8.in_sub));
            step();
        end
        bus8.in_valid = 1'b0;
        n_cmp++;
        if (q8.size() != 0) begin
            n_fail++; $display("FAIL rnd_drain: got %0d pending want 0", q8.size());
        end
        q8.delete();
    endtask

    task automatic test_reset_inflight();
        res_t got, exp;
        bus8.out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus8.in_valid = 1'b1; bus8.in_a = 8'($urandom); bus8.in_b = 8'($urandom);
            bus8.in_sub = 1'($urandom);
            step();
        end
        bus8.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (bus8.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL rstfl_in_ready_during: got %b want 1", bus8.in_ready);
        end
        step();
        rst_n = 1'b1;
        n_cmp++;
        if ({bus8.out_valid, bus8.s_out, bus8.c_out, bus8.v_out, bus8.z_out} !== 12'h0) begin
            n_fail++; $display("FAIL rstfl_cleared: got %h want 0",
                               {bus8.out_valid, bus8.s_out, bus8.c_out, bus8.v_out, bus8.z_out});
        end
        bus8.out_ready = 1'b1;
        for (int cyc = 0; cyc < 4; cyc++) begin
            n_cmp++;
            if (bus8.out_valid !== 1'b0) begin
                n_fail++; $display("FAIL rstfl_ghost cyc%0d: got %b want 0", cyc, bus8.out_valid);
            end
            step();
        end
        bus8.in_valid = 1'b1; bus8.in_a = 8'h3C; bus8.in_b = 8'h51; bus8.in_sub = 1'b1;
        exp = model(8, 8'h3C, 8'h51, 1'b1);
        step();
        bus8.in_valid = 1'b0;
        step();
        got = {bus8.s_out, bus8.c_out, bus8.v_out, bus8.z_out};
        n_cmp++;
        if (bus8.out_valid !== 1'b1 || got !== exp) begin
            n_fail++; $display("FAIL rstfl_after: got valid=%b %h want valid=1 %h",
                               bus8.out_valid, got, exp);
        end
        step();
    endtask

    task automatic test_exhaustive_w3();
        res_t got, exp;
        bus3.out_ready = 1'b1;
        for (int cyc = 0; cyc < 66; cyc++) begin
            bus3.in_valid = (cyc < 64);
            bus3.in_a = 3'(cyc >> 3); bus3.in_b = 3'(cyc); bus3.in_sub = 1'b0;
            #1;
            n_cmp++;
            if (bus3.out_valid !== 1'((cyc >= 1) && (cyc <= 64))) begin
                n_fail++; $display("FAIL w3_out_valid cyc%0d: got %b want %b",
                                   cyc, bus3.out_valid, (cyc >= 1) && (cyc <= 64));
            end
            if (bus3.out_valid === 1'b1 && q3.size() > 0) begin
                got = {5'b0, bus3.s_out, bus3.c_out, bus3.v_out, bus3.z_out};
                exp = q3.pop_front();
                n_cmp++;
                if (got !== exp) begin
                    n_fail++; $display("FAIL w3_result cyc%0d: got %h want %h", cyc, got, exp);
                end
            end
            if (bus3.in_valid && bus3.in_ready)
                q3.push_back(model(3, bus3.in_a, bus3.in_b, 1'b0));
            step();
        end
        bus3.in_valid = 1'b0;
        n_cmp++;
        if (q3.size() != 0) begin
            n_fail++; $display("FAIL w3_drain: got %0d pending want 0", q3.size());
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_stall();
        test_random();
        test_reset_inflight();
        test_exhaustive_w3();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
